port_rr_arbiter: RTL and testbench

Round-robin, packet-granular arbiter that shares one switch output port among `NUM_REQ` input-port requesters. A grant is held from the first beat to the `eop` beat of a packet, so packets from different sources never interleave on the output. A beat-count watchdog forcibly releases a grant whose packet runs past `MAX_LEN` beats. One instance sits in front of each output port's data mux inside `dut_top`; `gnt_id` drives that mux select.

---
 rtl/port_rr_arbiter_pkg.sv | 10 +
 rtl/port_rr_arbiter_pick.sv | 34 +++
 rtl/port_rr_arbiter.sv | 115 +++++++++++
 tb/tb_port_rr_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/port_rr_arbiter_pkg.sv
// Shared arbiter types and the per-output-port instantiation constants.
// One arbiter sits in front of each output port's data mux.
package port_rr_arbiter_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_e;

    localparam int NUM_PORTS   = 4;
    localparam int ARB_MAX_LEN = 16;

endpackage

// File: rtl/port_rr_arbiter_pick.sv
// Round-robin winner select: scan req from rr_ptr upward, wrapping, first set bit wins.
// Purely combinational; no state, no backpressure.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_rr_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDW-1:0]     o_gnt_id
);

    always_comb begin
        int  idx;
        logic found;
        o_gnt    = '0;
        o_gnt_id = '0;
        found    = 1'b0;
        idx      = 0;
        // Rotated scan: offset 0 is rr_ptr, index maps back modulo NUM_REQ.
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(i_rr_ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && i_req[idx]) begin
                found      = 1'b1;
                o_gnt[idx] = 1'b1;
                o_gnt_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/port_rr_arbiter.sv
// Packet-granular round-robin arbiter for one output port; grant registered one edge after req, held until eop or watchdog.
// No backpressure: valid/eop from the granted source only advance the beat count and release the grant.
module port_rr_arbiter
    import port_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_PORTS,
    parameter int MAX_LEN = ARB_MAX_LEN,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_valid,
    input  logic               i_eop,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDW-1:0]     o_gnt_id,
    output logic               o_busy,
    output logic               o_timeout_err
);

    localparam int              CW       = $clog2(MAX_LEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_LEN - 1);
    localparam logic [IDW-1:0]  ID_LAST  = IDW'(NUM_REQ - 1);

    arb_state_e         r_state, w_state;
    logic [NUM_REQ-1:0] r_gnt, w_gnt;
    logic [IDW-1:0]     r_gnt_id, w_gnt_id;
    logic               r_busy, w_busy;
    logic               r_timeout_err, w_timeout_err;
    logic [IDW-1:0]     r_rr_ptr, w_rr_ptr;
    logic [CW-1:0]      r_beat_cnt, w_beat_cnt;

    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IDW-1:0]     w_pick_id;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .i_req    (i_req),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_pick_gnt),
        .o_gnt_id (w_pick_id)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_gnt         <= '0;
            r_gnt_id      <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_rr_ptr      <= '0;
            r_beat_cnt    <= '0;
        end else begin
            r_state       <= w_state;
            r_gnt         <= w_gnt;
            r_gnt_id      <= w_gnt_id;
            r_busy        <= w_busy;
            r_timeout_err <= w_timeout_err;
            r_rr_ptr      <= w_rr_ptr;
            r_beat_cnt    <= w_beat_cnt;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_gnt         = r_gnt;
        w_gnt_id      = r_gnt_id;
        w_busy        = r_busy;
        w_timeout_err = 1'b0;
        w_rr_ptr      = r_rr_ptr;
        w_beat_cnt    = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (|i_req) begin
                    w_state    = BUSY;
                    w_gnt      = w_pick_gnt;
                    w_gnt_id   = w_pick_id;
                    w_busy     = 1'b1;
                    w_rr_ptr   = (w_pick_id == ID_LAST) ? '0 : w_pick_id + 1'b1;
                    w_beat_cnt = '0;
                end
            end
            BUSY: begin
                // eop wins over the watchdog on the MAX_LEN-th beat.
                if (i_valid) begin
                    if (i_eop) begin
                        w_state    = IDLE;
                        w_gnt      = '0;
                        w_busy     = 1'b0;
                        w_beat_cnt = '0;
                    end else if (r_beat_cnt == CNT_LAST) begin
                        w_state       = IDLE;
                        w_gnt         = '0;
                        w_busy        = 1'b0;
                        w_timeout_err = 1'b1;
                        w_beat_cnt    = '0;
                    end else begin
                        w_beat_cnt = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign o_gnt         = r_gnt;
    assign o_gnt_id      = r_gnt_id;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_port_rr_arbiter.sv
// Directed bench for port_rr_arbiter: expected grant ids queued at stimulus time, checked when the grant appears.
module tb_port_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       valid;
    logic       eop;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout_err;

    int n_checks;
    int n_fail;
    int exp_q[$];

    port_rr_arbiter #(
        .NUM_REQ (4),
        .MAX_LEN (16)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_req         (req),
        .i_valid       (valid),
        .i_eop         (eop),
        .o_gnt         (gnt),
        .o_gnt_id      (gnt_id),
        .o_busy        (busy),
        .o_timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the next expected winner and compare against the registered grant.
    task automatic expect_grant(input string tag);
        int id;
        logic [3:0] oh;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
            return;
        end
        id = exp_q.pop_front();
        oh = 4'b0001 << id;
        chk({tag, "_gnt_id"}, 32'(gnt_id), 32'(id));
        chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic send_beats(input string tag, input int n, input bit last_eop);
        for (int k = 0; k < n; k++) begin
            valid = 1'b1;
            eop   = last_eop && (k == n - 1);
            tick();
            if (!eop) begin
                chk({tag, "_held"}, 32'(busy), 32'd1);
                chk({tag, "_no_to"}, 32'(timeout_err), 32'd0);
            end
        end
        valid = 1'b0;
        eop   = 1'b0;
    endtask

    task automatic chk_idle(input string tag, input logic exp_to);
        chk({tag, "_gnt0"}, 32'(gnt), 32'd0);
        chk({tag, "_busy0"}, 32'(busy), 32'd0);
        chk({tag, "_to"}, 32'(timeout_err), 32'(exp_to));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        req      = 4'b0000;
        valid    = 1'b0;
        eop      = 1'b0;

        tick();
        tick();
        chk_idle("reset", 1'b0);
        chk("reset_gnt_id", 32'(gnt_id), 32'd0);
        #3 reset = 1'b0;

        // Single requester, 3-beat packet.
        tick();
        req = 4'b0100;
        exp_q.push_back(2);
        tick();
        expect_grant("single");
        send_beats("single", 3, 1'b1);
        chk_idle("single_rel", 1'b0);
        req = 4'b0000;

        // Fairness from a fresh pointer.
        #2 reset = 1'b1;
        #1 chk("rst_pulse_busy", 32'(busy), 32'd0);
        #2 reset = 1'b0;
        tick();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(i % 4);
            tick();
            expect_grant("fair");
            send_beats("fair", 2, 1'b1);
            chk_idle("fair_gap", 1'b0);
        end

        // Wrap and skip: grant 3, then 0101 gives 0 then 2.
        req = 4'b1000;
        exp_q.push_back(3);
        tick();
        expect_grant("wrap3");
        req = 4'b0101;
        send_beats("wrap3", 2, 1'b1);
        chk_idle("wrap3_rel", 1'b0);
        exp_q.push_back(0);
        exp_q.push_back(2);
        tick();
        expect_grant("wrap0");
        send_beats("wrap0", 1, 1'b1);
        tick();
        expect_grant("skip2");
        req = 4'b0000;
        send_beats("skip2", 2, 1'b1);
        chk_idle("skip2_rel", 1'b0);

        // Watchdog with a valid gap mid-packet.
        req = 4'b0010;
        exp_q.push_back(1);
        tick();
        expect_grant("wd");
        req = 4'b0000;
        send_beats("wd_a", 8, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tick();
            chk("wd_gap_busy", 32'(busy), 32'd1);
        end
        send_beats("wd_b", 7, 1'b0);
        chk("wd_15_busy", 32'(busy), 32'd1);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk_idle("wd_fire", 1'b1);
        tick();
        chk("wd_pulse_end", 32'(timeout_err), 32'd0);

        // Exactly MAX_LEN beats ending in eop is a normal release.
        req = 4'b0010;
        exp_q.push_back(1);
        tick();
        expect_grant("len16");
        req = 4'b0000;
        send_beats("len16", 16, 1'b1);
        chk_idle("len16_rel", 1'b0);

        // Granted port drops req mid-packet.
        req = 4'b0001;
        exp_q.push_back(0);
        tick();
        expect_grant("drop");
        req = 4'b0000;
        send_beats("drop", 4, 1'b1);
        chk_idle("drop_rel", 1'b0);

        // Stray eop while idle; pointer must still point at port 1.
        valid = 1'b1;
        eop   = 1'b1;
        tick();
        valid = 1'b0;
        eop   = 1'b0;
        chk_idle("stray", 1'b0);
        req = 4'b1111;
        exp_q.push_back(1);
        tick();
        expect_grant("post_stray");

        // Async reset mid-packet, then 1010 from a reset pointer.
        send_beats("pre_rst", 1, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_idle("async_rst", 1'b0);
        chk("async_rst_gnt_id", 32'(gnt_id), 32'd0);
        req = 4'b1010;
        #1 reset = 1'b0;
        exp_q.push_back(1);
        tick();
        expect_grant("after_rst");
        req = 4'b0000;
        send_beats("after_rst", 2, 1'b1);
        chk_idle("after_rst_rel", 1'b0);

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
